// File: rtl/xbus_copy_master.sv
// xbus_copy_master: xbus initiator that copies a block of 32-bit words from a
// source word address to a destination word address. It reads up to BURST
// words into a local buffer, then writes them back in the same order, one
// access outstanding at a time.
//
// Ports:
//   clk, rstn                  clock, synchronous active-high reset
//   cmd_valid/cmd_ready        command handshake
//   cmd_src, cmd_dst, cmd_len  source/destination word address, word count
//   busy, done, err            status: in progress, completion / timeout pulses
//   ma_select, ma_addr,
//   ma_data, ma_rnw, ma_be     xbus request (single-cycle select)
//   xbs_ack, xbs_data          xbus slave ack pulse and read data
module xbus_copy_master #(
    parameter int unsigned BURST   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_src,
    input  logic [31:0] cmd_dst,
    input  logic [15:0] cmd_len,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        ma_select,
    output logic [31:0] ma_addr,
    output logic [31:0] ma_data,
    output logic        ma_rnw,
    output logic [3:0]  ma_be,
    input  logic        xbs_ack,
    input  logic [31:0] xbs_data
);

    // CW holds a chunk size 0..BURST; IW indexes the buffer.
    localparam int unsigned CW = $clog2(BURST + 1);
    localparam int unsigned IW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam int unsigned TW = 10;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        FIN
    } state_t;

    state_t        state, state_n;
    logic [31:0]   src, src_n;
    logic [31:0]   dst, dst_n;
    logic [15:0]   rem, rem_n;
    logic [CW-1:0] chunk, chunk_n;
    logic [CW-1:0] idx, idx_n;
    logic [TW-1:0] wcnt, wcnt_n;
    logic          accept;
    logic          buf_we;
    logic [31:0]   wr_word;
    logic [31:0]   word_buf [BURST];

    logic          cmd_ready_n, busy_n, done_n, err_n;
    logic          sel_n, rnw_n;
    logic [31:0]   addr_n, data_n;
    logic [3:0]    be_n;

    function automatic logic [CW-1:0] clip_chunk(input logic [15:0] n);
        return (32'(n) >= BURST) ? CW'(BURST) : CW'(n);
    endfunction

    // Next-state, datapath and next-output logic
    always_comb begin
        state_n = state;
        src_n   = src;
        dst_n   = dst;
        rem_n   = rem;
        chunk_n = chunk;
        idx_n   = idx;
        wcnt_n  = wcnt + TW'(1);
        buf_we  = 1'b0;
        done_n  = 1'b0;
        err_n   = 1'b0;
        accept  = cmd_valid && cmd_ready;

        case (state)
            IDLE: begin
                if (accept) begin
                    src_n   = cmd_src;
                    dst_n   = cmd_dst;
                    rem_n   = cmd_len;
                    chunk_n = clip_chunk(cmd_len);
                    idx_n   = '0;
                    state_n = (cmd_len == 16'd0) ? FIN : RD_REQ;
                end
            end
            RD_REQ: begin
                wcnt_n  = '0;
                state_n = RD_WAIT;
            end
            RD_WAIT: begin
                if (xbs_ack) begin
                    buf_we = 1'b1;
                    idx_n  = idx + CW'(1);
                    src_n  = src + 32'd1;
                    if (idx_n == chunk) begin
                        idx_n   = '0;
                        state_n = WR_REQ;
                    end else begin
                        state_n = RD_REQ;
                    end
                end else if (wcnt == TW'(TIMEOUT - 1)) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end
            end
            WR_REQ: begin
                wcnt_n  = '0;
                state_n = WR_WAIT;
            end
            WR_WAIT: begin
                if (xbs_ack) begin
                    idx_n = idx + CW'(1);
                    dst_n = dst + 32'd1;
                    rem_n = rem - 16'd1;
                    if (rem_n == 16'd0) begin
                        state_n = FIN;
                    end else if (idx_n == chunk) begin
                        chunk_n = clip_chunk(rem_n);
                        idx_n   = '0;
                        state_n = RD_REQ;
                    end else begin
                        state_n = WR_REQ;
                    end
                end else if (wcnt == TW'(TIMEOUT - 1)) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end
            end
            FIN: begin
                done_n  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // Ready only after a full idle cycle, so it returns the cycle after done/err.
        cmd_ready_n = (state == IDLE) && (state_n == IDLE);
        busy_n      = (state_n != IDLE);
        sel_n       = (state_n == RD_REQ) || (state_n == WR_REQ);
        be_n        = sel_n ? 4'hF : 4'h0;
        addr_n      = (state_n == RD_REQ) ? src_n :
                      (state_n == WR_REQ) ? dst_n : ma_addr;
        rnw_n       = (state_n == RD_REQ) ? 1'b1 :
                      (state_n == WR_REQ) ? 1'b0 : ma_rnw;
        // Forward the word being captured this cycle (single-word chunk case).
        wr_word     = (buf_we && (idx == idx_n)) ? xbs_data : word_buf[IW'(idx_n)];
        data_n      = (state_n == WR_REQ) ? wr_word : ma_data;
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rstn) begin
            state     <= IDLE;
            src       <= '0;
            dst       <= '0;
            rem       <= '0;
            chunk     <= '0;
            idx       <= '0;
            wcnt      <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            ma_select <= 1'b0;
            ma_addr   <= '0;
            ma_data   <= '0;
            ma_rnw    <= 1'b0;
            ma_be     <= 4'h0;
        end else begin
            state     <= state_n;
            src       <= src_n;
            dst       <= dst_n;
            rem       <= rem_n;
            chunk     <= chunk_n;
            idx       <= idx_n;
            wcnt      <= wcnt_n;
            cmd_ready <= cmd_ready_n;
            busy      <= busy_n;
            done      <= done_n;
            err       <= err_n;
            ma_select <= sel_n;
            ma_addr   <= addr_n;
            ma_data   <= data_n;
            ma_rnw    <= rnw_n;
            ma_be     <= be_n;
        end
    end

    // Read buffer; contents are don't-care across reset
    always_ff @(posedge clk) begin
        if (buf_we) begin
            word_buf[IW'(idx)] <= xbs_data;
        end
    end

endmodule
